// File: rtl/accel_pkg.sv
// Shared types and default widths for the accelerator output stages.
// The FSM state type and the accumulator width helper are shared across psum stages.
package accel_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      REQUANT = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   localparam int DEF_PROD_WIDTH  = 14;
   localparam int DEF_OUT_WIDTH   = 8;
   localparam int DEF_SHIFT_WIDTH = 5;

   // Growth of log2(chunks) bits makes the running sum overflow-free.
   function automatic int acc_width(input int prod_width, input int num_chunk_max);
      return prod_width + $clog2(num_chunk_max);
   endfunction

endpackage

// File: rtl/psum_requant.sv
// Round-half-up arithmetic right shift of a partial sum, then clip (PSUM_SAT_EN) or wrap to OUT_WIDTH.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module psum_requant
   import accel_pkg::*;
#(
   parameter int ACC_WIDTH   = 18,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
   input  logic signed [ACC_WIDTH-1:0]   acc,
   input  logic        [SHIFT_WIDTH-1:0] shift,
   output logic signed [OUT_WIDTH-1:0]   r_clipped,
   output logic                          sat
);

   // One extra bit so adding the rounding bias cannot overflow.
   localparam int RW = ACC_WIDTH + 1;

   logic        [RW-1:0] bias;
   logic signed [RW-1:0] sum;
   logic signed [RW-1:0] rounded;

   always_comb begin
      bias = '0;
      if (shift != '0) begin
         bias = RW'(1) << (shift - SHIFT_WIDTH'(1));
      end
      sum     = {acc[ACC_WIDTH-1], acc} + bias;
      rounded = sum >>> shift;
   end

`ifdef PSUM_SAT_EN
   localparam logic signed [RW-1:0] OUT_MAX = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

   always_comb begin
      r_clipped = rounded[OUT_WIDTH-1:0];
      sat       = 1'b0;
      if (rounded > OUT_MAX) begin
         r_clipped = OUT_MAX[OUT_WIDTH-1:0];
         sat       = 1'b1;
      end else if (rounded < OUT_MIN) begin
         r_clipped = OUT_MIN[OUT_WIDTH-1:0];
         sat       = 1'b1;
      end
   end
`else
   logic unused_hi;

   assign r_clipped = rounded[OUT_WIDTH-1:0];
   assign sat       = 1'b0;
   assign unused_hi = ^rounded[RW-1:OUT_WIDTH];
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates signed chunk dot products and requantizes on the final chunk (clip when PSUM_SAT_EN).
// Latency: final chunk accepted at edge N, result valid for the handshake at edge N+2.
// Backpressure: o_ready low from final chunk until result taken; result held while i_ready low.
module psum_accumulator
   import accel_pkg::*;
#(
   parameter int PROD_WIDTH    = DEF_PROD_WIDTH,
   parameter int NUM_CHUNK_MAX = 16,
   parameter int CNT_WIDTH     = $clog2(NUM_CHUNK_MAX) + 1,
   parameter int ACC_WIDTH     = acc_width(PROD_WIDTH, NUM_CHUNK_MAX),
   parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
   parameter int SHIFT_WIDTH   = DEF_SHIFT_WIDTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic signed [PROD_WIDTH-1:0]  i_product,
   input  logic                          i_last,
   input  logic        [SHIFT_WIDTH-1:0] i_shift,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic signed [OUT_WIDTH-1:0]   o_result,
   output logic        [CNT_WIDTH-1:0]   o_chunk_cnt,
   output logic                          o_sat
);

   state_t                       state, state_nxt;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic        [SHIFT_WIDTH-1:0] shift_q;
   logic                         accept;
   logic                         chunk_final;
   logic signed [OUT_WIDTH-1:0]  rq_result;
   logic                         rq_sat;

   assign accept      = i_valid && o_ready;
   // A reduction that never flags i_last is force-closed on its last legal chunk.
   assign chunk_final = i_last || (o_chunk_cnt == CNT_WIDTH'(NUM_CHUNK_MAX - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      case (state)
         ACCUM: begin
            o_ready = i_rst_n;
            if (accept && chunk_final) begin
               state_nxt = REQUANT;
            end
         end
         REQUANT: begin
            state_nxt = OUTPUT;
         end
         OUTPUT: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: begin
            state_nxt = ACCUM;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc         <= '0;
         o_chunk_cnt <= '0;
         shift_q     <= '0;
         o_result    <= '0;
         o_sat       <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc         <= acc + {{(ACC_WIDTH - PROD_WIDTH){i_product[PROD_WIDTH-1]}}, i_product};
                  o_chunk_cnt <= o_chunk_cnt + CNT_WIDTH'(1);
                  if (chunk_final) begin
                     shift_q <= i_shift;
                  end
               end
            end
            REQUANT: begin
               o_result <= rq_result;
               o_sat    <= rq_sat;
            end
            OUTPUT: begin
               if (i_ready) begin
                  acc         <= '0;
                  o_chunk_cnt <= '0;
               end
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   psum_requant #(
      .ACC_WIDTH   (ACC_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_requant (
      .acc       (acc),
      .shift     (shift_q),
      .r_clipped (rq_result),
      .sat       (rq_sat)
   );

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed table-driven bench for psum_accumulator; expectations follow PSUM_SAT_EN when defined.
module tb_psum_accumulator;

   localparam int PW = 14;
   localparam int CW = 5;
   localparam int OW = 8;
   localparam int SW = 5;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 i_valid;
   logic                 o_ready;
   logic signed [PW-1:0] i_product;
   logic                 i_last;
   logic        [SW-1:0] i_shift;
   logic                 o_valid;
   logic                 i_ready;
   logic signed [OW-1:0] o_result;
   logic        [CW-1:0] o_chunk_cnt;
   logic                 o_sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psum_accumulator dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_product   (i_product),
      .i_last      (i_last),
      .i_shift     (i_shift),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_chunk_cnt (o_chunk_cnt),
      .o_sat       (o_sat)
   );

   typedef struct {
      int n;
      int c0;
      int c1;
      int c2;
      int fill;
      int last;
      int shift;
      int exp_cnt;
      int res_sat;
      int sat_flag;
      int res_wrap;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " o_valid"}, int'(o_valid), 0);
      chk({tag, " o_result"}, int'(o_result), 0);
      chk({tag, " o_chunk_cnt"}, int'(o_chunk_cnt), 0);
      chk({tag, " o_sat"}, int'(o_sat), 0);
   endtask

   function automatic int chunk_of(input vec_t v, input int k);
      if (k == 0) return v.c0;
      if (k == 1) return v.c1;
      if (k == 2) return v.c2;
      return v.fill;
   endfunction

   // Feeds chunks back to back; non-final chunks carry a junk shift to prove it is latched only on the final one.
   task automatic feed(input vec_t v, input string tag);
      for (int k = 0; k < v.n; k++) begin
         i_valid   = 1'b1;
         i_product = PW'(chunk_of(v, k));
         i_last    = (k == v.n - 1) && (v.last != 0);
         i_shift   = (k == v.n - 1) ? SW'(v.shift) : 5'd31;
         tick();
         chk($sformatf("%s cnt after chunk %0d", tag, k), int'(o_chunk_cnt), k + 1);
      end
      i_valid   = 1'b0;
      i_last    = 1'b0;
      i_product = '0;
   endtask

   task automatic run_vec(input int idx);
      vec_t  v;
      int    exp_r;
      int    exp_s;
      string tag;
      v   = vecs[idx];
      tag = $sformatf("vec%0d", idx);
`ifdef PSUM_SAT_EN
      exp_r = v.res_sat;
      exp_s = v.sat_flag;
`else
      exp_r = v.res_wrap;
      exp_s = 0;
`endif
      chk({tag, " o_ready before"}, int'(o_ready), 1);
      feed(v, tag);
      chk({tag, " o_valid in requant"}, int'(o_valid), 0);
      chk({tag, " o_ready in requant"}, int'(o_ready), 0);
      tick();
      chk({tag, " o_valid"}, int'(o_valid), 1);
      chk({tag, " o_result"}, int'(o_result), exp_r);
      chk({tag, " o_sat"}, int'(o_sat), exp_s);
      chk({tag, " o_chunk_cnt"}, int'(o_chunk_cnt), v.exp_cnt);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk({tag, " o_valid after handshake"}, int'(o_valid), 0);
      chk({tag, " cnt after handshake"}, int'(o_chunk_cnt), 0);
      chk({tag, " o_ready after handshake"}, int'(o_ready), 1);
   endtask

   initial begin
      int   held;
      vec_t seven;
      vec_t three_fifty;

      //          n   c0     c1     c2    fill last sh cnt sat_r  satf wrap_r
      vecs[0]  = '{3,  100,   -30,   50,   0,   1,   2, 3,  30,    0,   30};
      vecs[1]  = '{1,  -5,    0,     0,    0,   1,   1, 1,  -2,    0,   -2};
      vecs[2]  = '{1,  -7,    0,     0,    0,   1,   0, 1,  -7,    0,   -7};
      vecs[3]  = '{3,  4096,  4096,  4096, 0,   1,   0, 3,  127,   1,   0};
      vecs[4]  = '{16, 1,     1,     1,    1,   0,   0, 16, 16,    0,   16};
      vecs[5]  = '{1,  -3,    0,     0,    0,   1,   1, 1,  -1,    0,   -1};
      vecs[6]  = '{1,  5,     0,     0,    0,   1,   1, 1,  3,     0,   3};
      vecs[7]  = '{2,  -8000, -8192, 0,    0,   1,   2, 2,  -128,  1,   48};
      vecs[8]  = '{1,  127,   0,     0,    0,   1,   0, 1,  127,   0,   127};
      vecs[9]  = '{1,  128,   0,     0,    0,   1,   0, 1,  127,   1,   -128};
      vecs[10] = '{1,  -128,  0,     0,    0,   1,   0, 1,  -128,  0,   -128};
      vecs[11] = '{1,  -129,  0,     0,    0,   1,   0, 1,  -128,  1,   127};
      vecs[12] = '{1,  8191,  0,     0,    0,   1,  13, 1,  1,     0,   1};
      vecs[13] = '{1,  -6,    0,     0,    0,   1,   2, 1,  -1,    0,   -1};
      seven       = '{1, 7,  0,  0,  0, 1, 0, 1, 7, 0, 7};
      three_fifty = '{3, 50, 50, 50, 0, 0, 0, 3, 0, 0, 0};

      rst_n     = 1'b0;
      i_valid   = 1'b0;
      i_product = '0;
      i_last    = 1'b0;
      i_shift   = '0;
      i_ready   = 1'b0;
      repeat (3) tick();
      chk("reset o_ready", int'(o_ready), 0);
      check_idle("reset");
      rst_n = 1'b1;
      #1;
      chk("release o_ready", int'(o_ready), 1);

      for (int i = 0; i < 14; i++) begin
         run_vec(i);
      end

      // Backpressure: result held, chunks refused, then a clean restart.
      feed(vecs[0], "bp");
      tick();
      chk("bp o_valid", int'(o_valid), 1);
      held = int'(o_result);
      chk("bp first result", held, 30);
      for (int c = 0; c < 3; c++) begin
         i_valid   = 1'b1;
         i_product = 14'sd99;
         i_last    = 1'b1;
         tick();
         chk($sformatf("bp hold%0d o_valid", c), int'(o_valid), 1);
         chk($sformatf("bp hold%0d o_result", c), int'(o_result), held);
         chk($sformatf("bp hold%0d o_ready", c), int'(o_ready), 0);
         chk($sformatf("bp hold%0d cnt", c), int'(o_chunk_cnt), 3);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("bp released o_valid", int'(o_valid), 0);
      chk("bp released cnt", int'(o_chunk_cnt), 0);
      run_vec_inline(seven, "bp next");

      // Reset in the middle of a reduction, with a stale result still on o_result.
      feed(three_fifty, "rst");
      chk("rst pre o_ready", int'(o_ready), 1);
      rst_n = 1'b0;
      tick();
      chk("rst mid o_ready", int'(o_ready), 0);
      check_idle("rst mid");
      rst_n = 1'b1;
      #1;
      chk("rst release o_ready", int'(o_ready), 1);
      run_vec_inline(seven, "rst next");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic run_vec_inline(input vec_t v, input string tag);
      feed(v, tag);
      tick();
      chk({tag, " o_valid"}, int'(o_valid), 1);
      chk({tag, " o_result"}, int'(o_result), v.res_wrap);
      chk({tag, " o_chunk_cnt"}, int'(o_chunk_cnt), v.exp_cnt);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk({tag, " o_valid after"}, int'(o_valid), 0);
   endtask

endmodule
